// File: rtl/heap_push_siftup_if.sv
// Push-side handshake for the heap insert path: one signed key per accepted transfer.
// A transfer happens on a rising clock edge where push_valid && push_ready; the producer
// holds push_data stable while push_valid is high, and push_ready may drop without a transfer.
interface heap_push_siftup_if #(
    parameter int DW = 32
);
    logic          push_valid;
    logic [DW-1:0] push_data;
    logic          push_ready;

    modport master (
        output push_valid,
        output push_data,
        input  push_ready
    );

    modport slave (
        input  push_valid,
        input  push_data,
        output push_ready
    );
endinterface

// File: rtl/heap_push_siftup.sv
// Min-heap insert: append the pushed key at index heap_count, then sift it toward the root
// with one compare/swap per cycle. The heap is exported flat with entry 0 in the MSBs.
module heap_push_siftup #(
    parameter int DEPTH = 5,
    parameter int DW    = 32,
    parameter int CW    = 16
) (
    input  logic                  system1000,
    input  logic                  system1000_rst,
    input  logic                  flush,
    heap_push_siftup_if.slave     push,
    output logic                  busy,
    output logic                  overflow,
    output logic [CW-1:0]         heap_count,
    output logic [DEPTH*DW-1:0]   heap_flat,
    output logic                  state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        SIFT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cur_q, cur_d;
    logic [CW-1:0]         count_q, count_d;
    logic signed [DW-1:0]  heap_q [DEPTH];
    logic signed [DW-1:0]  heap_d [DEPTH];

    logic [CW-1:0]         parent;
    logic signed [DW-1:0]  parent_key;
    logic signed [DW-1:0]  cur_key;
    logic                  full;
    logic                  push_ready_int;

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                heap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                heap_q[i] <= heap_d[i];
            end
        end
    end

    assign full           = (count_q >= CW'(DEPTH));
    assign push_ready_int = (state_q == IDLE) && !full && !flush;
    assign push.push_ready = push_ready_int;
    assign overflow       = (state_q == IDLE) && full && push.push_valid && !flush;
    assign busy           = (state_q == SIFT);
    assign heap_count     = count_q;
    assign state_dbg      = state_q;

    // Parent index wraps when cur is 0; that case is excluded before any swap.
    assign parent = (cur_q - CW'(1)) >> 1;

    always_comb begin
        parent_key = '0;
        cur_key    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == parent) parent_key = heap_q[i];
            if (CW'(i) == cur_q)  cur_key    = heap_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            heap_d[i] = heap_q[i];
        end

        if (flush) begin
            state_d = IDLE;
            cur_d   = '0;
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                heap_d[i] = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (push.push_valid && push_ready_int) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (CW'(i) == count_q) heap_d[i] = push.push_data;
                        end
                        cur_d   = count_q;
                        count_d = count_q + CW'(1);
                        state_d = SIFT;
                    end
                end
                SIFT: begin
                    // Equal keys stop the sift, so duplicates keep arrival order along a path.
                    if (cur_q == '0 || parent_key <= cur_key) begin
                        state_d = IDLE;
                    end else begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (CW'(i) == parent) heap_d[i] = cur_key;
                            if (CW'(i) == cur_q)  heap_d[i] = parent_key;
                        end
                        cur_d = parent;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        heap_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            heap_flat[(DEPTH-i)*DW-1 -: DW] = heap_q[i];
        end
    end

endmodule

// File: doc/heap_push_siftup.md
Name: heap_push_siftup

Overview:
- Insert side of the HeapSort priority queue; complement of the pop/root-replace step.
- Accepts one signed key per push handshake, appends it at index `count`, then sifts it up one compare/swap per cycle until the min-heap property holds.
- Exposes the heap as a flat vector in the same packing the pop path consumes. Element 0 sits in the MSBs, so the pop path can take it unmodified.

Parameters:
- DEPTH, 5, heap capacity in entries
- DW, 32, key width; keys are signed two's complement
- CW, 16, width of count and index values

Ports:
- system1000  in  1  clock; all state changes on the rising edge
- system1000_rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of the whole heap
- push_valid  in  1  push request
- push_data  in  DW  key to insert (signed)
- push_ready  out  1  push accepted on a cycle where push_valid && push_ready
- busy  out  1  sift in progress (state SIFT)
- overflow  out  1  one-cycle pulse: push_valid seen in IDLE while full
- heap_count  out  CW  number of valid entries, 0..DEPTH
- heap_flat  out  DEPTH*DW  entry i at bits [(DEPTH-i)*DW-1 -: DW]; entry 0 is the root (minimum)

Behaviour:
- Reset values (asynchronous): all entries 0, heap_count 0, cur 0, state IDLE, busy 0, overflow 0. push_ready is therefore 1 out of reset.
- push_ready (combinational) = (state==IDLE) && (heap_count<DEPTH) && !flush.
- Accept (IDLE, push_valid && push_ready):
  - entry[heap_count] <= push_data
  - cur <= heap_count
  - heap_count <= heap_count+1
  - state <= SIFT
- SIFT, one decision per cycle, with parent=(cur-1)>>1 (CW-bit unsigned arithmetic):
  - If cur==0, or entry[parent] <= entry[cur] (signed compare): state <= IDLE.
  - Otherwise swap entry[parent] and entry[cur], set cur <= parent, and stay in SIFT.
- Latency:
  - push_ready is low for k+1 cycles after the accept edge, where k = number of swaps (0..floor(log2(DEPTH))).
  - For DEPTH=5: at most 3 cycles low.
  - heap_flat is valid and heap-ordered in every cycle where state==IDLE.
- Equal keys never swap, so the sift stops at the first equal-or-smaller parent.
- Full condition:
  - With heap_count==DEPTH, push_ready=0.
  - If push_valid=1 in IDLE, overflow pulses high for exactly that cycle.
  - The data is dropped; heap and count are unchanged.
  - No overflow is reported while in SIFT; the producer is simply stalled.
- flush:
  - Has priority over everything except reset, in any state including mid-SIFT.
  - Next edge: all entries 0, heap_count 0, state IDLE, overflow 0.
  - A push presented with flush is not accepted, since push_ready is forced low.
- Reset mid-SIFT: immediate return to the reset values; the partial sift is discarded.
- Entries at index >= heap_count hold stale or zero data and carry no meaning. The pop side must mask them using heap_count.
- Index width: cur and heap_count are CW bits. DEPTH must be <= 2^CW-1; the design does not check this.

Test Plan:
- Reset then push 7 → heap_flat root 7, heap_count 1, push_ready low exactly 1 cycle (k=0), busy high 1 cycle.
- Continue pushes 3, 5, 1 back to back, each issued when push_ready=1 → entries [1,3,5,7], heap_count 4. The push of 1 holds push_ready low 3 cycles (2 swaps: idx3→1→0).
- Push -2 → [-2,1,5,7,3], heap_count 5, 2 swaps. Confirms signed compare (0xFFFFFFFE ranks below 1).
- Full heap, then push_valid=1 with data 9 for 2 cycles → overflow high for both cycles, heap_flat and heap_count unchanged, push_ready 0.
- Empty heap, push 4 then 4 → [4,4], no swap, push_ready low exactly 1 cycle each.
- Push 1 into [3,7,5,9]; assert flush on the first SIFT cycle → next edge heap_count 0, all entries 0, IDLE. Repeat the scenario with system1000_rst asserted mid-edge instead → same reset values, output changes asynchronously.
